// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitcher trigger path: FSM state encoding,
// trigger mode codes and the saturating statistics increment.
package glitch_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_HOLDOFF  = 2'd2
  } trig_state_t;

  typedef logic [1:0] trig_mode_t;

  localparam trig_mode_t TRIG_RISE  = 2'b00;
  localparam trig_mode_t TRIG_FALL  = 2'b01;
  localparam trig_mode_t TRIG_BOTH  = 2'b10;
  localparam trig_mode_t TRIG_LEVEL = 2'b11;

  localparam int COUNT_W = 16;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/trigger_conditioner_if.sv
// Handshake between the trigger conditioner (master) and the glitch pulser
// (slave): the fire strobe goes downstream, the busy flag comes back.
interface trigger_conditioner_if;
  logic trigger_o;
  logic busy_i;

  modport master (output trigger_o, input  busy_i);
  modport slave  (input  trigger_o, output busy_i);
endinterface

// File: rtl/trigger_conditioner_sync_filter.sv
// Synchronizes the raw trigger pin and debounces it: a new level is accepted
// only after it has been stable for filter_i+1 synchronized cycles.
module sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig_pin_i,
  input  logic [FILTER_W-1:0] filter_i,
  output logic                f_o,
  output logic                upd_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   f_q, f_d;
  logic                   upd_q, upd_d;
  logic [FILTER_W-1:0]    fcnt_q, fcnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trig_pin_i};
    f_d    = f_q;
    fcnt_d = fcnt_q;
    upd_d  = 1'b0;
    if (s == f_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == filter_i) begin
      f_d    = s;
      fcnt_d = '0;
      upd_d  = 1'b1;
    end else begin
      fcnt_d = fcnt_q + FILTER_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      f_q    <= 1'b0;
      fcnt_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      f_q    <= f_d;
      fcnt_q <= fcnt_d;
      upd_q  <= upd_d;
    end
  end

  // upd is registered alongside f so both describe the same accepted edge.
  assign f_o   = f_q;
  assign upd_o = upd_q;

endmodule

// File: rtl/trigger_conditioner.sv
// Turns the conditioned trigger pin into a single-cycle fire strobe for the
// pulser, applying arm/disarm, one-shot, holdoff and busy suppression.
module trigger_conditioner
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trig_pin_i,
  input  logic                   arm_i,
  input  logic                   disarm_i,
  input  logic [1:0]             mode_i,
  input  logic                   one_shot_i,
  input  logic [FILTER_W-1:0]    filter_i,
  input  logic [HOLDOFF_W-1:0]   holdoff_i,
  trigger_conditioner_if.master  pulser,
  output logic                   armed_o,
  output logic                   missed_o,
  output logic [COUNT_W-1:0]     trig_count_o
);

  logic f, upd, ev;

  sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_W    (FILTER_W)
  ) u_sync_filter (
    .clk        (clk),
    .rst        (rst),
    .trig_pin_i (trig_pin_i),
    .filter_i   (filter_i),
    .f_o        (f),
    .upd_o      (upd)
  );

  trig_state_t           state_q, state_d;
  logic [HOLDOFF_W-1:0]  hcnt_q, hcnt_d;
  logic                  trigger_q, trigger_d;
  logic                  missed_q, missed_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  // f already holds the newly accepted level when upd is high.
  always_comb begin
    ev = 1'b0;
    unique case (mode_i)
      TRIG_RISE:  ev = upd & f;
      TRIG_FALL:  ev = upd & ~f;
      TRIG_BOTH:  ev = upd;
      TRIG_LEVEL: ev = f;
      default:    ev = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    trigger_d = 1'b0;
    missed_d  = missed_q;
    count_d   = count_q;

    if (arm_i) missed_d = 1'b0;

    unique case (state_q)
      ST_DISARMED: begin
        // An event coinciding with the arming strobe is deliberately ignored.
        if (arm_i && !disarm_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (disarm_i) begin
          state_d = ST_DISARMED;
        end else if (ev && !pulser.busy_i) begin
          trigger_d = 1'b1;
          count_d   = sat_inc(count_q);
          if (one_shot_i) begin
            state_d = ST_DISARMED;
          end else begin
            state_d = ST_HOLDOFF;
            hcnt_d  = holdoff_i;
          end
        end else if (ev && pulser.busy_i) begin
          missed_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (disarm_i) begin
          state_d = ST_DISARMED;
        end else if (hcnt_q == '0 && !pulser.busy_i) begin
          state_d = ST_ARMED;
        end else if (hcnt_q != '0) begin
          hcnt_d = hcnt_q - HOLDOFF_W'(1);
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISARMED;
      hcnt_q    <= '0;
      trigger_q <= 1'b0;
      missed_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      trigger_q <= trigger_d;
      missed_q  <= missed_d;
      count_q   <= count_d;
    end
  end

  assign pulser.trigger_o = trigger_q;
  assign armed_o          = (state_q == ST_ARMED);
  assign missed_o         = missed_q;
  assign trig_count_o     = count_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Scoreboard bench for trigger_conditioner: a pin-history reference model
// predicts fire cycles and status; a negedge monitor compares the DUT.
module tb_trigger_conditioner;
  import glitch_pkg::*;

  localparam int SYNC = 2;
  localparam int FW   = 8;
  localparam int HW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pin, arm, disarm, one_shot, busy;
  logic [1:0]    mode;
  logic [FW-1:0] filter;
  logic [HW-1:0] holdoff;
  logic          armed, missed;
  logic [15:0]   count;

  trigger_conditioner_if pif ();
  assign pif.busy_i = busy;

  trigger_conditioner #(
    .SYNC_STAGES (SYNC),
    .FILTER_W    (FW),
    .HOLDOFF_W   (HW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trig_pin_i   (pin),
    .arm_i        (arm),
    .disarm_i     (disarm),
    .mode_i       (mode),
    .one_shot_i   (one_shot),
    .filter_i     (filter),
    .holdoff_i    (holdoff),
    .pulser       (pif),
    .armed_o      (armed),
    .missed_o     (missed),
    .trig_count_o (count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int cnt; } fire_t;
  fire_t exp_q[$];

  int n;             // clock edges since reset release
  int m_state;       // 0 disarmed, 1 armed, 2 holdoff
  bit m_missed;
  int m_count;
  int m_fire_edge, m_hold;
  bit m_f, m_upd;
  bit hist[$];       // pin value sampled at each edge, newest last

  function automatic bit pin_at(input int back);
    if (back >= hist.size()) return 1'b0;
    return hist[hist.size()-1-back];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_state = 0; m_missed = 0; m_count = 0;
      m_fire_edge = 0; m_hold = 0; m_f = 0; m_upd = 0;
      hist.delete();
      exp_q.delete();
    end else begin
      bit ev, same, v;
      n++;
      hist.push_back(pin);
      if (hist.size() > 300) void'(hist.pop_front());

      case (mode)
        TRIG_RISE: ev = m_upd && m_f;
        TRIG_FALL: ev = m_upd && !m_f;
        TRIG_BOTH: ev = m_upd;
        default:   ev = m_f;
      endcase

      if (m_state == 1 && !disarm && ev && busy) m_missed = 1;
      else if (arm) m_missed = 0;

      if (m_state == 0) begin
        if (arm && !disarm) m_state = 1;
      end else if (m_state == 1) begin
        if (disarm) m_state = 0;
        else if (ev && !busy) begin
          if (m_count < 16'hFFFF) m_count++;
          exp_q.push_back('{cyc: n, cnt: m_count});
          m_fire_edge = n;
          m_hold = int'(holdoff);
          m_state = one_shot ? 0 : 2;
        end
      end else begin
        if (disarm) m_state = 0;
        else if (n >= m_fire_edge + m_hold + 1 && !busy) m_state = 1;
      end

      // A level is accepted once the synchronized pin has shown it for filter+1 cycles.
      v = pin_at(SYNC);
      same = 1;
      for (int k = SYNC; k <= SYNC + int'(filter); k++)
        if (pin_at(k) != v) same = 0;
      m_upd = same && (v != m_f);
      if (m_upd) m_f = v;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (pif.trigger_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fire", pif.trigger_o, 0);
        end else begin
          fire_t e;
          e = exp_q.pop_front();
          check("fire_cycle", n, e.cyc);
          check("fire_count", count, e.cnt);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < n) begin
        void'(exp_q.pop_front());
        check("missing_fire", pif.trigger_o, 1);
      end
      check("armed", armed, m_state == 1);
      check("missed", missed, m_missed);
      check("count", count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic strobe_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic wait_fire(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (pif.trigger_o) seen = 1;
      else tick();
    end
    if (!seen) check(name, pif.trigger_o, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; pin = 0; arm = 0; disarm = 0; one_shot = 0; busy = 0;
    mode = TRIG_RISE; filter = '0; holdoff = 16'd5;
    tick(3);
    check("rst_trigger", pif.trigger_o, 0);
    check("rst_armed", armed, 0);
    check("rst_missed", missed, 0);
    check("rst_count", count, 0);
    rst = 0;

    // Rising edge, filter 0, holdoff 5.
    strobe_arm(); tick(3);
    pin = 1; tick(20); pin = 0; tick(15);
    check("p1_count", count, 1);

    // Filter 4: short pulse rejected, long pulse accepted.
    filter = 8'd4; tick(2);
    pin = 1; tick(3); pin = 0; tick(15);
    pin = 1; tick(10); pin = 0; tick(20);
    check("p2_count", count, 2);

    // Both edges, no holdoff.
    filter = '0; mode = TRIG_BOTH; holdoff = '0; tick(5);
    pin = 1; tick(20); pin = 0; tick(15);
    check("p3_count", count, 4);

    // Busy pulser: event is missed, arm strobe clears the flag.
    mode = TRIG_RISE; busy = 1; tick(2);
    pin = 1; tick(10); pin = 0; tick(10);
    check("p4_missed", missed, 1);
    strobe_arm(); tick();
    check("p4_missed_clr", missed, 0);
    busy = 0; tick(5);

    // One-shot.
    one_shot = 1; tick(2);
    pin = 1; tick(10); pin = 0; tick(40);
    pin = 1; tick(10); pin = 0; tick(10);
    check("p5_armed", armed, 0);
    check("p5_count", count, 5);
    strobe_arm(); tick(3);
    pin = 1; tick(10); pin = 0; tick(10);
    check("p5_count2", count, 6);
    one_shot = 0;

    // Level mode re-fires after holdoff; reset asserted mid-holdoff.
    strobe_arm(); mode = TRIG_LEVEL; holdoff = 16'd12; tick();
    pin = 1;
    wait_fire("p6_first_fire", 50);
    tick();
    wait_fire("p6_refire", 50);
    tick(3);
    rst = 1; #1;
    check("p6_rst_trigger", pif.trigger_o, 0);
    check("p6_rst_armed", armed, 0);
    check("p6_rst_missed", missed, 0);
    check("p6_rst_count", count, 0);
    pin = 0; tick(2); rst = 0; tick(3);

    // Arm and disarm together: disarm wins.
    mode = TRIG_RISE; holdoff = 16'd3;
    arm = 1; disarm = 1; tick(); arm = 0; disarm = 0; tick(2);
    check("p7_armed", armed, 0);
    strobe_arm(); tick(5);

    // Randomized traffic.
    filter = FW'($urandom_range(0, 3));
    holdoff = HW'($urandom_range(0, 6));
    tick(10);
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      pin = ($urandom_range(0, 3) != 0) ? ~pin : pin;
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        busy   = ($urandom_range(0, 7) == 0);
        arm    = ($urandom_range(0, 9) == 0);
        disarm = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) mode = trig_mode_t'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) one_shot = ~one_shot;
        if ($urandom_range(0, 19) == 0) holdoff = HW'($urandom_range(0, 6));
        tick();
      end
    end
    arm = 0; disarm = 0; busy = 0; pin = 0;
    tick(30);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
